apb_bridge_ctrl: RTL and testbench
==================================

// Module: apb_bridge_ctrl
// PURPOSE
//  APB-side controller of the AHB-to-APB bridge; sits directly upstream of the APB signal bundle.
//  Accepts pre-decoded AHB transfers (address, select, direction; write data one cycle later).
//  Sequences each transfer through APB SETUP/ACCESS phases, driving pselx/penable/paddr/pwrite/pwdata.
//  Stalls AHB via hreadyout and returns prdata as hrdata.
// PARAMETERS
//  ADDR_W   32  address width (haddr/paddr)
//  DATA_W   32  data width (hwdata/pwdata/prdata/hrdata)
//  NSEL     4   number of APB slave selects (width of tempselx/pselx)
//  CNT_W    16  width of completed-transfer counter
// PORTS
//  hclk       in   1       bridge clock, single domain
//  hresetn    in   1       asynchronous active-low reset
//  valid      in   1       qualified AHB address phase (NONSEQ/SEQ, hsel, hready)
//  haddr      in   ADDR_W  AHB address, sampled with valid
//  hwrite     in   1       1=write, sampled with valid
//  tempselx   in   NSEL    decoded APB slave select, sampled with valid
//  hwdata     in   DATA_W  AHB write data, sampled in WWAIT
//  prdata     in   DATA_W  APB read data
//  hreadyout  out  1       0 stalls AHB data phase
//  hrdata     out  DATA_W  read data to AHB
//  hresp      out  1       decode-error response (see CONFIGURATION)
//  pselx      out  NSEL    APB select, registered
//  penable    out  1       APB enable, registered
//  pwrite     out  1       APB direction, registered
//  paddr      out  ADDR_W  APB address, registered
//  pwdata     out  DATA_W  APB write data, registered
//  xfer_cnt   out  CNT_W   completed APB transfers, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (async, hresetn=0): state=IDLE; hreadyout=1; pselx=0, penable=0, pwrite=0, paddr=0,
//    pwdata=0, hresp=0, xfer_cnt=0. Reset mid-transfer aborts it immediately; no completion counted.
//  FSM states: IDLE, WWAIT, SETUP, ACCESS.
//   IDLE:   hreadyout=1. valid&hwrite -> WWAIT; valid&!hwrite -> SETUP; else stay.
//           On valid, latch haddr/hwrite/tempselx into holding regs.
//   WWAIT:  hreadyout=0; capture hwdata -> SETUP.
//   SETUP:  pselx=held sel, penable=0, paddr/pwrite (and pwdata for writes) from holding regs;
//           hreadyout=0 -> ACCESS.
//   ACCESS: pselx held, penable=1; hreadyout=1; hrdata=prdata (combinational pass-through).
//           xfer_cnt++ on exit. valid&hwrite -> WWAIT; valid&!hwrite -> SETUP (back-to-back,
//           no IDLE bubble, new request latched); else -> IDLE.
//  Leaving ACCESS: pselx=0, penable=0. paddr/pwrite/pwdata hold their last values.
//  No pready: every APB access is exactly 1 SETUP + 1 ACCESS cycle.
//  Latency: read = 2 stall-free cycles after address phase (SETUP, ACCESS);
//    write = 3 (WWAIT, SETUP, ACCESS).
//  valid is ignored in WWAIT/SETUP (hreadyout=0 prevents a legal AHB request there).
//  tempselx=0 with valid: transfer still sequenced, pselx=0 throughout; counts as completed.
// CONFIGURATION
//  APB_DECODE_ERR_EN defined: tempselx not one-hot (zero or multiple bits) is a decode error.
//    No APB transfer: pselx/penable stay 0. Two-cycle AHB ERROR response, replacing SETUP/ACCESS:
//    cycle 1: hresp=1, hreadyout=0; cycle 2: hresp=1, hreadyout=1. Not counted in xfer_cnt.
//  APB_DECODE_ERR_EN undefined: hresp tied 0; all selects are sequenced as above.
// STRUCTURE
//  bridge_pkg: state enum (IDLE, WWAIT, SETUP, ACCESS [,ERR1, ERR2]), default width localparams.
//  Flat module; no sub-module warranted (one-hot check is a single function in the package).
// TESTING
//  Read: valid, haddr=0x8000_0010, hwrite=0, sel=4'b0001, prdata=0xCAFE_F00D ->
//    SETUP: psel=1, pen=0; ACCESS: pen=1, hrdata=0xCAFE_F00D, hreadyout=1; xfer_cnt=1.
//  Write: haddr=0x8400_0004, sel=4'b0010, hwdata=0x1234_5678 next cycle ->
//    WWAIT: hreadyout=0; SETUP/ACCESS: pwrite=1, pwdata=0x1234_5678, paddr matches.
//  Back-to-back: read then write issued in the ACCESS cycle -> ACCESS goes straight to WWAIT,
//    pselx drops for exactly 1 cycle, xfer_cnt increments by 2 in total.
//  Reset mid-op: hresetn=0 during SETUP -> pselx=0, penable=0, hreadyout=1 without waiting
//    for a clock edge; xfer_cnt=0.
//  Counter wrap: CNT_W=4, 17 transfers -> xfer_cnt=1.
//  APB_DECODE_ERR_EN: sel=4'b0011 -> hresp high 2 cycles, hreadyout 0 then 1, pselx stays 0;
//    without the macro, the same stimulus drives pselx=4'b0011.

Source files
------------

// File: rtl/apb_bridge_ctrl_pkg.sv
// Shared types and defaults for the APB-side bridge controller.
// The ERR1/ERR2 states are only reachable when APB_DECODE_ERR_EN is defined.
package apb_bridge_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NSEL   = 4;
  localparam int DEF_CNT_W  = 16;

  // Widest slave-select vector the one-hot helper accepts.
  localparam int SEL_MAX = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  // True when exactly one select bit is set.
  function automatic logic is_onehot(input logic [SEL_MAX-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/apb_bridge_ctrl.sv
// APB-side controller of the AHB-to-APB bridge.
// Takes pre-decoded AHB transfers and runs each through one APB SETUP and
// one APB ACCESS cycle, stalling the AHB data phase via hreadyout.
// Optional feature macro: APB_DECODE_ERR_EN -- a select that is not one-hot
// produces a two-cycle AHB ERROR response instead of an APB transfer.
//
// Handshake: an AHB request is taken whenever valid is high while the
// controller reports hreadyout=1 (IDLE, ACCESS, ERR2); valid is ignored in
// every stalled cycle. Write data arrives one cycle after its request.
module apb_bridge_ctrl
  import apb_bridge_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSEL   = DEF_NSEL,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [NSEL-1:0]   tempselx,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              hreadyout,
  output logic [DATA_W-1:0] hrdata,
  output logic              hresp,
  output logic [NSEL-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [CNT_W-1:0]  xfer_cnt
);

  state_t state;
  state_t next_state;

  // Request captured at address phase, used once write data has arrived.
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_write;
  logic [NSEL-1:0]   hold_sel;

  logic              accept;
  logic              from_hold;
  logic [ADDR_W-1:0] src_addr;
  logic              src_write;
  logic [NSEL-1:0]   src_sel;
  logic              sel_err;

  assign accept    = valid && ((state == IDLE) || (state == ACCESS) || (state == ERR2));

  // In WWAIT the request comes from the holding registers; otherwise a
  // read request goes straight from the AHB inputs into SETUP.
  assign from_hold = (state == WWAIT);
  assign src_addr  = from_hold ? hold_addr  : haddr;
  assign src_write = from_hold ? hold_write : hwrite;
  assign src_sel   = from_hold ? hold_sel   : tempselx;

`ifdef APB_DECODE_ERR_EN
  assign sel_err = !is_onehot(SEL_MAX'(src_sel));
`else
  assign sel_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, ACCESS, ERR2: begin
        if (valid) begin
          if (hwrite)       next_state = WWAIT;
          else if (sel_err) next_state = ERR1;
          else              next_state = SETUP;
        end else begin
          next_state = IDLE;
        end
      end
      WWAIT:   next_state = sel_err ? ERR1 : SETUP;
      SETUP:   next_state = ACCESS;
      ERR1:    next_state = ERR2;
      default: next_state = IDLE;
    endcase
  end

  // AHB-facing outputs decoded from the current state.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    case (state)
      WWAIT, SETUP: hreadyout = 1'b0;
      ACCESS:       hrdata    = prdata;
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ERR2:         hresp     = 1'b1;
      default:      ;
    endcase
  end

  // Capture the AHB request on every accepted address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_sel   <= '0;
    end else if (accept) begin
      hold_addr  <= haddr;
      hold_write <= hwrite;
      hold_sel   <= tempselx;
    end
  end

  // Registered APB signals, loaded on entry to SETUP/ACCESS. Address,
  // direction and write data keep their last values between transfers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pselx   <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      case (next_state)
        SETUP: begin
          pselx   <= src_sel;
          penable <= 1'b0;
          paddr   <= src_addr;
          pwrite  <= src_write;
          if (src_write) pwdata <= hwdata;
        end
        ACCESS:  penable <= 1'b1;
        default: begin
          pselx   <= '0;
          penable <= 1'b0;
        end
      endcase
    end
  end

  // Every ACCESS lasts one cycle, so each ACCESS cycle is one completion.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)              xfer_cnt <= '0;
    else if (state == ACCESS)  xfer_cnt <= xfer_cnt + 1'b1;
  end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Bench for apb_bridge_ctrl. Expected behaviour is derived per transfer
// (phase sequence, select, address, data, completion count), not per state.
module tb_apb_bridge_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NSEL   = 4;
  localparam int CNT_W  = 4;

`ifdef APB_DECODE_ERR_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic              hclk;
  logic              hresetn;
  logic              valid;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [NSEL-1:0]   tempselx;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] prdata;
  logic              hreadyout;
  logic [DATA_W-1:0] hrdata;
  logic              hresp;
  logic [NSEL-1:0]   pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [CNT_W-1:0]  xfer_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: total completed transfers and last APB write data.
  int                exp_cnt   = 0;
  logic [DATA_W-1:0] last_wdata = '0;

  apb_bridge_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL), .CNT_W(CNT_W)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .haddr(haddr),
    .hwrite(hwrite), .tempselx(tempselx), .hwdata(hwdata), .prdata(prdata),
    .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp), .pselx(pselx),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .xfer_cnt(xfer_cnt)
  );

  // Clock.
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit exp_err(input logic [NSEL-1:0] s);
    return DEC_EN && ($countones(s) != 1);
  endfunction

  function automatic logic [CNT_W-1:0] exp_count();
    return CNT_W'(exp_cnt % (1 << CNT_W));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".hready"}, hreadyout, 1);
    check({tag, ".psel"},   pselx,     0);
    check({tag, ".pen"},    penable,   0);
    check({tag, ".hresp"},  hresp,     0);
    check({tag, ".cnt"},    xfer_cnt,  exp_count());
  endtask

  // Called at a negedge; leaves the bench at the next negedge.
  task automatic idle_cycle();
    valid = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    check_idle("idle");
  endtask

  // Issues one transfer while the DUT can accept it, then checks every
  // phase. Returns at the negedge of its last phase so a following call
  // lands its address phase in that cycle (back-to-back).
  task automatic do_xfer(input logic [ADDR_W-1:0] addr, input logic wr,
                         input logic [NSEL-1:0] sel, input logic [DATA_W-1:0] wdata,
                         input logic [DATA_W-1:0] rdata);
    bit err;
    err      = exp_err(sel);
    valid    = 1'b1;
    haddr    = addr;
    hwrite   = wr;
    tempselx = sel;
    hwdata   = $urandom;
    @(posedge hclk);
    #1;
    valid    = 1'b0;
    haddr    = $urandom;
    hwrite   = 1'($urandom);
    tempselx = NSEL'($urandom);
    hwdata   = wdata;
    if (wr) begin
      @(negedge hclk);
      check("wwait.hready", hreadyout, 0);
      check("wwait.psel",   pselx,     0);
      check("wwait.pen",    penable,   0);
      check("wwait.hresp",  hresp,     0);
      @(posedge hclk);
      #1 hwdata = $urandom;
    end
    if (err) begin
      @(negedge hclk);
      check("err1.hresp",  hresp,     1);
      check("err1.hready", hreadyout, 0);
      check("err1.psel",   pselx,     0);
      check("err1.pen",    penable,   0);
      @(posedge hclk);
      @(negedge hclk);
      check("err2.hresp",  hresp,     1);
      check("err2.hready", hreadyout, 1);
      check("err2.psel",   pselx,     0);
      check("err2.pen",    penable,   0);
      check("err2.cnt",    xfer_cnt,  exp_count());
    end else begin
      if (wr) last_wdata = wdata;
      @(negedge hclk);
      check("setup.psel",   pselx,     sel);
      check("setup.pen",    penable,   0);
      check("setup.hready", hreadyout, 0);
      check("setup.paddr",  paddr,     addr);
      check("setup.pwrite", pwrite,    wr);
      check("setup.pwdata", pwdata,    last_wdata);
      @(posedge hclk);
      #1 prdata = rdata;
      @(negedge hclk);
      check("access.psel",   pselx,     sel);
      check("access.pen",    penable,   1);
      check("access.hready", hreadyout, 1);
      check("access.hresp",  hresp,     0);
      check("access.paddr",  paddr,     addr);
      check("access.pwrite", pwrite,    wr);
      if (!wr) check("access.hrdata", hrdata, rdata);
      check("access.cnt",    xfer_cnt,  exp_count());
      exp_cnt++;
    end
  endtask

  task automatic reset_mid_setup();
    valid    = 1'b1;
    haddr    = 32'h8800_0020;
    hwrite   = 1'b0;
    tempselx = 4'b0100;
    @(posedge hclk);
    #1 valid = 1'b0;
    @(negedge hclk);
    check("rst_mid.setup_psel", pselx, 4'b0100);
    #2 hresetn = 1'b0;
    #1;
    check("rst_mid.psel",   pselx,     0);
    check("rst_mid.pen",    penable,   0);
    check("rst_mid.hready", hreadyout, 1);
    check("rst_mid.cnt",    xfer_cnt,  0);
    check("rst_mid.paddr",  paddr,     0);
    exp_cnt    = 0;
    last_wdata = '0;
    @(negedge hclk);
    hresetn = 1'b1;
    idle_cycle();
  endtask

  initial begin
    logic [NSEL-1:0] s;
    bit              err_prev;
    hresetn  = 1'b0;
    valid    = 1'b0;
    haddr    = '0;
    hwrite   = 1'b0;
    tempselx = '0;
    hwdata   = '0;
    prdata   = '0;
    @(negedge hclk);
    @(negedge hclk);
    check("rst.hready", hreadyout, 1);
    check("rst.psel",   pselx,     0);
    check("rst.pen",    penable,   0);
    check("rst.pwrite", pwrite,    0);
    check("rst.paddr",  paddr,     0);
    check("rst.pwdata", pwdata,    0);
    check("rst.hresp",  hresp,     0);
    check("rst.cnt",    xfer_cnt,  0);
    hresetn = 1'b1;
    idle_cycle();

    // Directed read and write.
    do_xfer(32'h8000_0010, 1'b0, 4'b0001, '0, 32'hCAFE_F00D);
    idle_cycle();
    do_xfer(32'h8400_0004, 1'b1, 4'b0010, 32'h1234_5678, '0);
    idle_cycle();

    // Back-to-back read then write, no idle between.
    do_xfer(32'h8000_0100, 1'b0, 4'b1000, '0, 32'h0BAD_BEEF);
    do_xfer(32'h8000_0104, 1'b1, 4'b0100, 32'hA5A5_5A5A, '0);
    idle_cycle();

    // Multi-bit and empty selects.
    do_xfer(32'h8C00_0008, 1'b0, 4'b0011, '0, 32'h5555_AAAA);
    idle_cycle();
    do_xfer(32'h8C00_000C, 1'b1, 4'b0000, 32'hFEED_0001, '0);
    idle_cycle();

    reset_mid_setup();

    // 17 completions on a 4-bit counter wrap to 1.
    for (int i = 0; i < 17; i++)
      do_xfer(32'h9000_0000 + 32'(i * 4), 1'(i % 2), 4'b0001, 32'(i), 32'(~i));
    idle_cycle();
    check("wrap.cnt", xfer_cnt, 1);

    // Randomised traffic.
    err_prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) s = NSEL'($urandom);
      else                           s = NSEL'(1 << $urandom_range(0, NSEL - 1));
      if (err_prev || $urandom_range(0, 1) == 0) idle_cycle();
      do_xfer($urandom, 1'($urandom), s, $urandom, $urandom);
      err_prev = exp_err(s);
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
